// File: rtl/sram_port_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_port_ctrl_if : bus-side write/read request and read response channels
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sram_port_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_WMASKS-1:0] wr_be;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr, rdata_ready,
    input  wr_ready, rd_ready, rdata_valid, rdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr, rdata_ready,
    output wr_ready, rd_ready, rdata_valid, rdata
  );
endinterface

`default_nettype wire

// File: rtl/sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// sram_port_ctrl : request/response front-end for a 1R1W byte-masked SRAM
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_port_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  wire                   clk,
  input  wire                   nrst,
  sram_port_ctrl_if.slave       bus,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  wire  [DATA_WIDTH-1:0] sram_dout1
);

  logic                  r_infl;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_q0;
  logic [DATA_WIDTH-1:0] r_q1;

  logic                  w_wr_en;
  logic                  w_coll;
  logic                  w_pop;
  logic                  w_accept;
  logic [2:0]            w_occ;

  // Port 0 is a straight pass-through; an all-zero mask is a no-op.
  assign w_wr_en     = bus.wr_valid & (|bus.wr_be);
  assign bus.wr_ready = 1'b1;
  assign sram_csb0   = ~w_wr_en;
  assign sram_wmask0 = bus.wr_be;
  assign sram_addr0  = bus.wr_addr;
  assign sram_din0   = bus.wr_data;

  // Holding off a same-address read guarantees it sees the new write.
  assign w_coll   = w_wr_en & bus.rd_valid & (bus.wr_addr == bus.rd_addr);
  assign w_pop    = (r_count != 2'd0) & bus.rdata_ready;
  assign w_occ    = {1'b0, r_count} + {2'b00, r_infl} - {2'b00, w_pop};
  assign bus.rd_ready = ~w_coll & (w_occ < 3'd2);
  assign w_accept = bus.rd_valid & bus.rd_ready;

  assign sram_csb1  = ~w_accept;
  assign sram_addr1 = bus.rd_addr;

  assign bus.rdata_valid = (r_count != 2'd0);
  assign bus.rdata       = r_q0;

  // dout1 is only valid at the edge right after the access, so push on r_infl.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_infl  <= 1'b0;
      r_count <= 2'd0;
      r_q0    <= '0;
      r_q1    <= '0;
    end else begin
      r_infl <= w_accept;
      case ({r_infl, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_q0 <= sram_dout1;
          else                 r_q1 <= sram_dout1;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_q0    <= r_q1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_q0 <= r_q1;
            r_q1 <= sram_dout1;
          end else begin
            r_q0 <= sram_dout1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_port_ctrl : directed self-checking bench with a behavioural macro
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_port_ctrl;

  logic        clk;
  logic        nrst;
  logic        sram_csb0;
  logic [3:0]  sram_wmask0;
  logic [10:0] sram_addr0;
  logic [31:0] sram_din0;
  logic        sram_csb1;
  logic [10:0] sram_addr1;
  logic [31:0] sram_dout1;

  int n_cmp;
  int n_fail;

  sram_port_ctrl_if bus ();

  sram_port_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .bus        (bus),
    .sram_csb0  (sram_csb0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: ports register at posedge, read data appears and writes
  // commit at the following negedge (read before write), dout dies after posedge.
  logic [31:0] mem [0:2047];
  logic        m_wp, m_rp;
  logic [10:0] m_wa, m_ra;
  logic [31:0] m_wd;
  logic [3:0]  m_wm;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    sram_dout1 = 32'h0;
  end

  always @(posedge clk) begin
    m_wp = !sram_csb0; m_wa = sram_addr0; m_wd = sram_din0; m_wm = sram_wmask0;
    m_rp = !sram_csb1; m_ra = sram_addr1;
    #1 sram_dout1 = 'x;
    @(negedge clk);
    if (m_rp) sram_dout1 = mem[m_ra];
    if (m_wp)
      for (int b = 0; b < 4; b++)
        if (m_wm[b]) mem[m_wa][8*b +: 8] = m_wd[8*b +: 8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
  endtask

  task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
    tick();
    bus.wr_valid = 1'b0; bus.wr_be = '0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; bus.rdata_ready = 1'b1; idle();
    tick(); tick();
    #1;
    n_cmp++; if (sram_csb0 !== 1'b1) begin n_fail++; $display("FAIL reset_csb0: got %b want 1", sram_csb0); end
    n_cmp++; if (sram_csb1 !== 1'b1) begin n_fail++; $display("FAIL reset_csb1: got %b want 1", sram_csb1); end
    n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", bus.rdata_valid); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    bus.wr_valid = 1'b1; bus.wr_addr = 11'd5; bus.wr_data = 32'hDEADBEEF; bus.wr_be = 4'hF;
    #1;
    n_cmp++; if (sram_csb0 !== 1'b0) begin n_fail++; $display("FAIL wr_csb0: got %b want 0", sram_csb0); end
    n_cmp++; if ({sram_wmask0, sram_addr0, sram_din0} !== {4'hF, 11'd5, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wr_port0: got %h/%h/%h want f/005/deadbeef", sram_wmask0, sram_addr0, sram_din0); end
    tick();
    idle();
    bus.rd_valid = 1'b1; bus.rd_addr = 11'd5;
    #1;
    n_cmp++; if ({bus.rd_ready, sram_csb1, sram_addr1} !== {1'b1, 1'b0, 11'd5}) begin
      n_fail++; $display("FAIL rd_issue: got rdy=%b csb1=%b a1=%h want 1/0/005", bus.rd_ready, sram_csb1, sram_addr1); end
    tick();
    bus.rd_valid = 1'b0;
    #1;
    n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early: got %b want 0", bus.rdata_valid); end
    tick();
    n_cmp++; if (bus.rdata_valid !== 1'b1) begin n_fail++; $display("FAIL rd_latency: got %b want 1", bus.rdata_valid); end
    n_cmp++; if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", bus.rdata); end
    tick();
    n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL rd_popped: got %b want 0", bus.rdata_valid); end
  endtask

  task automatic test_byte_mask();
    do_write(11'd7, 32'h11223344, 4'hF);
    do_write(11'd7, 32'hAABBCCDD, 4'b0101);
    bus.wr_valid = 1'b1; bus.wr_addr = 11'd7; bus.wr_data = 32'hFFFFFFFF; bus.wr_be = 4'h0;
    #1;
    n_cmp++; if (sram_csb0 !== 1'b1) begin n_fail++; $display("FAIL be0_noop: got csb0=%b want 1", sram_csb0); end
    tick();
    idle();
    bus.rd_valid = 1'b1; bus.rd_addr = 11'd7;
    tick();
    bus.rd_valid = 1'b0;
    tick();
    n_cmp++; if (bus.rdata !== 32'h11BB33DD || bus.rdata_valid !== 1'b1) begin
      n_fail++; $display("FAIL byte_mask: got %h v=%b want 11bb33dd v=1", bus.rdata, bus.rdata_valid); end
    tick();
  endtask

  task automatic test_collision();
    bus.wr_valid = 1'b1; bus.wr_addr = 11'd9; bus.wr_data = 32'h0000CAFE; bus.wr_be = 4'hF;
    bus.rd_valid = 1'b1; bus.rd_addr = 11'd9;
    #1;
    n_cmp++; if ({bus.rd_ready, sram_csb1, sram_csb0} !== 3'b010) begin
      n_fail++; $display("FAIL coll_block: got rdy=%b csb1=%b csb0=%b want 0/1/0", bus.rd_ready, sram_csb1, sram_csb0); end
    tick();
    bus.wr_valid = 1'b0; bus.wr_be = '0;
    #1;
    n_cmp++; if (bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL coll_retry: got %b want 1", bus.rd_ready); end
    tick();
    bus.rd_valid = 1'b0;
    tick();
    n_cmp++; if (bus.rdata !== 32'h0000CAFE || bus.rdata_valid !== 1'b1) begin
      n_fail++; $display("FAIL coll_data: got %h v=%b want 0000cafe v=1", bus.rdata, bus.rdata_valid); end
    tick();
    bus.wr_valid = 1'b1; bus.wr_addr = 11'd10; bus.wr_data = 32'h12345678; bus.wr_be = 4'hF;
    bus.rd_valid = 1'b1; bus.rd_addr = 11'd5;
    #1;
    n_cmp++; if ({bus.rd_ready, sram_csb1, sram_csb0} !== 3'b100) begin
      n_fail++; $display("FAIL diff_addr: got rdy=%b csb1=%b csb0=%b want 1/0/0", bus.rd_ready, sram_csb1, sram_csb0); end
    tick();
    idle();
    bus.rd_valid = 1'b1; bus.rd_addr = 11'd10;
    tick();
    bus.rd_valid = 1'b0;
    n_cmp++; if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL diff_rd5: got %h want deadbeef", bus.rdata); end
    tick();
    n_cmp++; if (bus.rdata !== 32'h12345678) begin n_fail++; $display("FAIL diff_rd10: got %h want 12345678", bus.rdata); end
    tick();
  endtask

  task automatic test_backpressure();
    do_write(11'd1, 32'hA1A1A1A1, 4'hF);
    do_write(11'd2, 32'hA2A2A2A2, 4'hF);
    do_write(11'd3, 32'hA3A3A3A3, 4'hF);
    bus.rdata_ready = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_addr = 11'd1;
    #1;
    n_cmp++; if (bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_acc1: got %b want 1", bus.rd_ready); end
    tick();
    bus.rd_addr = 11'd2;
    #1;
    n_cmp++; if (bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_acc2: got %b want 1", bus.rd_ready); end
    tick();
    bus.rd_addr = 11'd3;
    #1;
    n_cmp++; if (bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full1: got %b want 0", bus.rd_ready); end
    tick();
    n_cmp++; if ({bus.rd_ready, sram_csb1} !== 2'b01) begin n_fail++; $display("FAIL bp_full2: got rdy=%b csb1=%b want 0/1", bus.rd_ready, sram_csb1); end
    n_cmp++; if (bus.rdata !== 32'hA1A1A1A1) begin n_fail++; $display("FAIL bp_hold: got %h want a1a1a1a1", bus.rdata); end
    tick();
    bus.rdata_ready = 1'b1;
    #1;
    n_cmp++; if (bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", bus.rd_ready); end
    n_cmp++; if (bus.rdata !== 32'hA1A1A1A1) begin n_fail++; $display("FAIL bp_first: got %h want a1a1a1a1", bus.rdata); end
    tick();
    bus.rd_valid = 1'b0;
    n_cmp++; if (bus.rdata !== 32'hA2A2A2A2 || bus.rdata_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: got %h v=%b want a2a2a2a2 v=1", bus.rdata, bus.rdata_valid); end
    tick();
    n_cmp++; if (bus.rdata !== 32'hA3A3A3A3 || bus.rdata_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_third: got %h v=%b want a3a3a3a3 v=1", bus.rdata, bus.rdata_valid); end
    tick();
    n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", bus.rdata_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) do_write(11'(i), 32'h100 + i, 4'hF);
    for (int i = 0; i < 20; i++) begin
      bus.rd_valid = (i < 16);
      bus.rd_addr  = 11'(i);
      #1;
      if (i < 16) begin
        n_cmp++; if (bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL stream_rdy[%0d]: got %b want 1", i, bus.rd_ready); end
      end
      if (i >= 2 && i < 18) begin
        n_cmp++; if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'h100 + i - 2) begin
          n_fail++; $display("FAIL stream_data[%0d]: got %h v=%b want %h v=1", i, bus.rdata, bus.rdata_valid, 32'h100 + i - 2); end
      end else begin
        n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle[%0d]: got %b want 0", i, bus.rdata_valid); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_midflight();
    bus.rd_valid = 1'b1; bus.rd_addr = 11'd3;
    tick();
    idle();
    nrst = 1'b0;
    #1;
    n_cmp++; if ({bus.rdata_valid, sram_csb0, sram_csb1} !== 3'b011) begin
      n_fail++; $display("FAIL mid_rst: got v=%b csb0=%b csb1=%b want 0/1/1", bus.rdata_valid, sram_csb0, sram_csb1); end
    tick(); tick();
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got %b want 0", i, bus.rdata_valid); end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_collision();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Request/response front-end that owns both ports of the 2048x32 1R1W byte-masked SRAM macro: it turns valid/ready write and read requests into the macro's active-low chip-select and address/data/mask port signals. It tracks each read through the macro's one-cycle access, captures the returned word at the correct edge, and buffers it in a 2-entry response queue with backpressure. It sits between the bus-side logic and the macro instance. The macro's clk0/clk1 are tied to `clk` at the parent level.

## Interface
- ADDR_WIDTH, 11, word address width
- DATA_WIDTH, 32, data word width
- NUM_WMASKS, 4, byte-enable count (DATA_WIDTH/8)
- clk  in  1  system clock; also drives macro clk0/clk1
- nrst  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when high with wr_valid
- wr_addr  in  ADDR_WIDTH  write word address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  NUM_WMASKS  byte enables, bit i = byte [8i+7:8i]
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted when high with rd_valid
- rd_addr  in  ADDR_WIDTH  read word address
- rdata_valid  out  1  response word available
- rdata_ready  in  1  consumer takes response
- rdata  out  DATA_WIDTH  response word (head of queue)
- sram_csb0  out  1  macro port-0 chip select, active low
- sram_wmask0  out  NUM_WMASKS  macro write mask
- sram_addr0  out  ADDR_WIDTH  macro write address
- sram_din0  out  DATA_WIDTH  macro write data
- sram_csb1  out  1  macro port-1 chip select, active low
- sram_addr1  out  ADDR_WIDTH  macro read address
- sram_dout1  in  DATA_WIDTH  macro read data

## Operation
- Write path is combinational pass-through. wr_ready = 1 always.
  - sram_csb0 = ~(wr_valid & |wr_be).
  - sram_wmask0/addr0/din0 = wr_be/wr_addr/wr_data.
  - A write with wr_be = 0 is accepted but keeps csb0 high (no-op).
- Read path:
  - sram_csb1 = ~(rd_valid & rd_ready). sram_addr1 = rd_addr.
  - Acceptance sets an in-flight flag `infl` for exactly one cycle.
- Capture: on the edge after acceptance, if `infl` = 1, sram_dout1 is pushed into the response queue. The macro invalidates dout1 shortly after that same edge, so sampling at any later edge is forbidden.
- Response queue: 2 entries, FIFO order, count 0..2. rdata = head entry; rdata_valid = (count != 0). Pop on rdata_valid & rdata_ready.
- Credit rule: rd_ready = ~coll & ((count + infl − pop) < 2). The queue can never overflow.
- Collision: coll = wr_valid & |wr_be & rd_valid & (wr_addr == rd_addr). While coll is high, rd_ready = 0, so the read issues in a later cycle and returns the new data. A write and read to different addresses in the same cycle both issue.
- Simultaneous push and pop: count unchanged, queue order preserved.
- Reset (async, nrst low): count = 0, infl = 0, queue contents discarded. Any in-flight read is dropped and never returned.
- Reset values: sram_csb0 = 1, sram_csb1 = 1, rdata_valid = 0, rdata = 0. rd_ready and wr_ready are combinational from inputs; wr_ready = 1.

## Timing
- Write: accepted at edge E0; macro registers at E0 and commits at the following negedge. A read accepted at E1 or later returns the written data.
- Read latency: accepted at E0 → captured at E1 → rdata_valid high in the cycle after E1, i.e. 1 cycle after the acceptance edge.
- Throughput: with rdata_ready held high, 1 read per cycle is sustained indefinitely.
- With rdata_ready low, at most 2 reads are outstanding (queued plus in-flight), then rd_ready = 0.
- rd_ready depends combinationally on rd_valid, rd_addr, wr_*, and rdata_ready. No other combinational input→output paths exist besides the port-0 pass-through.

## Test plan
- Write 0xDEADBEEF to addr 5 with be = 4'hF, then read addr 5 → rdata = 0xDEADBEEF with rdata_valid exactly 1 cycle after read acceptance.
- Byte mask: write 0x11223344 to addr 7 (be = F), then write 0xAABBCCDD to addr 7 (be = 4'b0101), then read addr 7 → 0x11BB33DD.
- Collision: same cycle write 0x0000CAFE to addr 9 and read addr 9 → rd_ready = 0 that cycle; read issues next cycle and returns 0x0000CAFE. The same case at different addresses → both issue.
- Backpressure: rdata_ready = 0, request reads of addr 1, 2, 3 back-to-back → first two accepted, rd_ready drops. Raise rdata_ready → data from addr 1 then addr 2 in order, then the addr-3 read issues.
- Streaming: 16 consecutive reads of addrs 0..15 with rdata_ready = 1 → 16 responses on 16 consecutive cycles, in order, rd_ready never low.
- Reset mid-flight: accept a read, assert nrst low before the capture edge → rdata_valid = 0, sram_csb0/1 = 1, and no stale response appears after release.
